alu_issue: RTL and testbench
============================

# alu_issue

Registered ID/EX issue stage for the single-issue RV32I core. It decodes a 32-bit instruction into the 4-bit ALU `Operation` code, selects and sign-extends the second operand, and presents `SrcA`, `SrcB` and `Operation` to the ALU from a one-entry pipeline register with a valid/ready handshake. It also supports synchronous flush and keeps a saturating count of illegal instructions.

## Interface

Parameters:
- `DATA_WIDTH`, 32: operand width.
- `OPCODE_LENGTH`, 4: width of the `Operation` code.
- `CNT_WIDTH`, 8: width of the illegal-instruction counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: decode stage offers an instruction.
- `in_ready`, output, 1: stage accepts this cycle.
- `instr`, input, 32: RV32I instruction word.
- `rs1_data`, input, DATA_WIDTH: register-file read of rs1.
- `rs2_data`, input, DATA_WIDTH: register-file read of rs2.
- `flush`, input, 1: discard the held entry and any same-cycle offer.
- `out_valid`, output, 1: entry presented to the ALU.
- `out_ready`, input, 1: EX consumes the entry.
- `SrcA`, output, DATA_WIDTH: ALU operand A.
- `SrcB`, output, DATA_WIDTH: ALU operand B.
- `Operation`, output, OPCODE_LENGTH: ALU operation code.
- `out_illegal`, output, 1: the held entry decoded as illegal.
- `illegal_cnt`, output, CNT_WIDTH: saturating count of accepted illegal instructions.

## Operation

Decode on `instr[6:0]`, `funct3 = instr[14:12]`, `funct7 = instr[31:25]`.

- **R-type (0110011), SrcB = rs2_data:**
  - funct3 000 with funct7 0000000: ADD, 0010.
  - funct3 000 with funct7 0100000: SUB, 0110.
  - funct3 111: AND, 0000.
  - funct3 110: OR, 0001.
  - funct3 100: XOR, 0101.
  - funct3 010: SLT, 0111.
  - For funct3 ≠ 000, funct7 must be 0000000; any other value is illegal.
- **I-type ALU (0010011), SrcB = sext(instr[31:20]):**
  - funct3 000: ADDI, 1100.
  - funct3 010: SLTI, 0011.
  - funct3 111: AND, 0000.
  - funct3 110: OR, 0001.
  - funct3 100: XOR, 0101.
- **Load (0000011), SrcB = sext(instr[31:20]):** Operation 0010 (ADD).
- **Store (0100011), SrcB = sext({instr[31:25], instr[11:7]}):** Operation 0010 (ADD).
- **Branch (1100011), funct3 000 (BEQ), SrcB = rs2_data:** Operation 1000 (EQUAL).
- **Anything else is illegal:** the entry is still accepted and flows with `SrcA = 0`, `SrcB = 0`, `Operation = 0000`, `out_illegal = 1`.
- `SrcA = rs1_data` for every legal instruction.
- **Sign extension:** bit 11 of the 12-bit immediate replicates up to DATA_WIDTH-1.

Handshake:
- `in_ready = !out_valid || out_ready`, purely combinational.
- **Accept:** `in_valid && in_ready && !flush` loads all payload registers and sets `out_valid = 1`.
- **Consume without refill:** `out_valid && out_ready` with no accept clears `out_valid`.
- **Stall:** while `out_valid && !out_ready`, the payload (`SrcA`, `SrcB`, `Operation`, `out_illegal`) holds bit-stable.
- **Flush:**
  - Highest priority: the next state is `out_valid = 0` regardless of `in_valid` or `out_ready`, and the same-cycle offer is dropped.
  - Payload registers may retain stale values; they are don't-care while `out_valid = 0`.
- **Counter:** increments by 1 on each accepted illegal instruction (accept condition with illegal decode), saturates at 2^CNT_WIDTH−1. A flushed offer is never counted.

## Timing

- Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N.
- Full throughput: one instruction per cycle when `out_ready` is held at 1.
- Reset (async assert, on `rst_n` low) sets `out_valid = 0`, `SrcA = 0`, `SrcB = 0`, `Operation = 0000`, `out_illegal = 0`, `illegal_cnt = 0`. `in_ready` is then 1.
- Reset asserted mid-stall drops the held entry.
- Release of `rst_n` is synchronous to `clk` (synchronized externally).
- Simultaneous consume and accept in one cycle replaces the entry with no bubble.

## Structure

- **Package `alu_pkg`:**
  - `alu_op_e`, a 4-bit enum with AND=0000, OR=0001, ADD=0010, SLTI=0011, XOR=0101, SUB=0110, SLT=0111, EQUAL=1000, ADDI=1100.
  - RV32I opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH.
  - funct7 constants.
- **Sub-module `alu_dec`:** purely combinational decode of instr to Operation, operand-B select, immediate and illegal flag. `alu_issue` holds only the handshake, flush, payload registers and counter.

## Test plan

- **ADD:** `instr = 0x002081B3` (add x3,x1,x2), rs1=5, rs2=7, `out_ready = 1` -> next cycle `out_valid = 1`, `Operation = 0010`, `SrcA = 5`, `SrcB = 7`.
- **ADDI and SUB:** `0xFFF00093` (addi x1,x0,-1) -> `Operation = 1100`, `SrcB = 0xFFFFFFFF`. `0x40208133` (sub) -> `Operation = 0110`.
- **Store immediate:** `0x0020A423` (sw x2,8(x1)), rs1=0x100 -> `Operation = 0010`, `SrcA = 0x100`, `SrcB = 8`.
- **Backpressure:**
  - Hold `out_ready = 0` for 3 cycles with a new `in_valid` -> `in_ready = 0` and the payload is unchanged throughout.
  - Raise `out_ready` -> the old entry is consumed and the new one is accepted in the same cycle with no bubble.
- **Flush with simultaneous `in_valid`:**
  - With `flush` high and an illegal `0xFFFFFFFF` offered, the next cycle shows `out_valid = 0` and `illegal_cnt` unchanged.
  - Assert `rst_n = 0` mid-stall -> all outputs go to 0 immediately.
- **Illegal instructions:** offer `0xFFFFFFFF` -> `out_illegal = 1`, `Operation = 0000`, `illegal_cnt = 1`. After 300 accepted illegals, `illegal_cnt = 255`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and RV32I decode constants for the ALU issue stage.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SLTI  = 4'b0011,
        ALU_XOR   = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_EQUAL = 4'b1000,
        ALU_ADDI  = 4'b1100
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_dec.sv
// Combinational RV32I decode: ALU operation, operand-B source, sign-extended
// immediate and illegal flag.
module alu_dec
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr_i,
    output alu_op_e               op_o,
    output logic                  use_imm_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic                  illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm12;
    logic        unused_rs1_field;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    // rs1 index is resolved by the register file upstream; only its data arrives here
    assign unused_rs1_field = ^instr_i[19:15];

    always_comb begin
        op_o      = ALU_AND;
        use_imm_o = 1'b0;
        imm12     = '0;
        illegal_o = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (funct3)
                    F3_ADD: begin
                        if (funct7 == F7_BASE)     op_o = ALU_ADD;
                        else if (funct7 == F7_ALT) op_o = ALU_SUB;
                        else                       illegal_o = 1'b1;
                    end
                    F3_AND:  op_o = ALU_AND;
                    F3_OR:   op_o = ALU_OR;
                    F3_XOR:  op_o = ALU_XOR;
                    F3_SLT:  op_o = ALU_SLT;
                    default: illegal_o = 1'b1;
                endcase
                if (funct3 != F3_ADD && funct7 != F7_BASE) illegal_o = 1'b1;
            end
            OPC_OP_IMM: begin
                use_imm_o = 1'b1;
                imm12     = instr_i[31:20];
                case (funct3)
                    F3_ADD:  op_o = ALU_ADDI;
                    F3_SLT:  op_o = ALU_SLTI;
                    F3_AND:  op_o = ALU_AND;
                    F3_OR:   op_o = ALU_OR;
                    F3_XOR:  op_o = ALU_XOR;
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use_imm_o = 1'b1;
                imm12     = instr_i[31:20];
                op_o      = ALU_ADD;
            end
            OPC_STORE: begin
                use_imm_o = 1'b1;
                imm12     = {instr_i[31:25], instr_i[11:7]};
                op_o      = ALU_ADD;
            end
            OPC_BRANCH: begin
                if (funct3 == F3_ADD) op_o = ALU_EQUAL;
                else                  illegal_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
        // Illegal entries still flow downstream but as a harmless all-zero AND
        if (illegal_o) begin
            op_o      = ALU_AND;
            use_imm_o = 1'b0;
        end
    end

    assign imm_o = {{(DATA_WIDTH-12){imm12[11]}}, imm12};

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue register: one-entry valid/ready pipeline stage holding ALU
// operands and operation, with flush and a saturating illegal counter.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_illegal,
    output logic [CNT_WIDTH-1:0]     illegal_cnt
);

    alu_op_e                  dec_op;
    logic                     dec_use_imm;
    logic [DATA_WIDTH-1:0]    dec_imm;
    logic                     dec_illegal;

    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    src_a_q, src_a_d;
    logic [DATA_WIDTH-1:0]    src_b_q, src_b_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic                     illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                     accept;

    alu_dec #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_dec (
        .instr_i   (instr),
        .op_o      (dec_op),
        .use_imm_o (dec_use_imm),
        .imm_o     (dec_imm),
        .illegal_o (dec_illegal)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        valid_d   = valid_q;
        src_a_d   = src_a_q;
        src_b_d   = src_b_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        // Flush wins over both refill and consume
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            src_a_d   = dec_illegal ? '0 : rs1_data;
            src_b_d   = dec_illegal ? '0 : (dec_use_imm ? dec_imm : rs2_data);
            op_d      = OPCODE_LENGTH'(dec_op);
            illegal_d = dec_illegal;
            if (dec_illegal && cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign SrcA        = src_a_q;
    assign SrcB        = src_b_q;
    assign Operation   = op_q;
    assign out_illegal = illegal_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        out_illegal;
    logic [7:0]  illegal_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    alu_issue #(
        .DATA_WIDTH(32),
        .OPCODE_LENGTH(4),
        .CNT_WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .Operation   (Operation),
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (SrcA !== 32'h0) $display("FAIL reset_srca got=%h exp=0", SrcA); else n_pass++;
        n_checks++; if (SrcB !== 32'h0) $display("FAIL reset_srcb got=%h exp=0", SrcB); else n_pass++;
        n_checks++; if (Operation !== 4'h0) $display("FAIL reset_op got=%h exp=0", Operation); else n_pass++;
        n_checks++; if (out_illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", out_illegal); else n_pass++;
        n_checks++; if (illegal_cnt !== 8'd0) $display("FAIL reset_cnt got=%0d exp=0", illegal_cnt); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
        step(); step();
        rst_n = 1'b1;
        $display("reset: out_valid=%b in_ready=%b cnt=%0d", out_valid, in_ready, illegal_cnt);
    endtask

    task automatic test_add();
        instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL add_valid got=%b exp=1", out_valid); else n_pass++;
        n_checks++; if (Operation !== 4'b0010) $display("FAIL add_op got=%b exp=0010", Operation); else n_pass++;
        n_checks++; if (SrcA !== 32'd5) $display("FAIL add_srca got=%h exp=5", SrcA); else n_pass++;
        n_checks++; if (SrcB !== 32'd7) $display("FAIL add_srcb got=%h exp=7", SrcB); else n_pass++;
        $display("add: op=%b a=%h b=%h", Operation, SrcA, SrcB);
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL add_drain got=%b exp=0", out_valid); else n_pass++;
    endtask

    // Back-to-back decode vectors; expected values computed by hand from the encodings.
    task automatic test_decode_table();
        logic [31:0] v_instr [0:8];
        logic [31:0] v_rs1   [0:8];
        logic [31:0] v_rs2   [0:8];
        logic [3:0]  v_op    [0:8];
        logic [31:0] v_a     [0:8];
        logic [31:0] v_b     [0:8];
        logic        v_ill   [0:8];
        v_instr = '{32'hFFF00093, 32'h40208133, 32'h0020A423, 32'hFFC12083, 32'h0020A1B3,
                    32'h00208063, 32'h00512093, 32'h0FF0F093, 32'h0220F1B3};
        v_rs1   = '{32'h0, 32'd10, 32'h100, 32'h2000, 32'd1, 32'd4, 32'h30, 32'h1, 32'd6};
        v_rs2   = '{32'h55, 32'd3, 32'h77, 32'd9, 32'd2, 32'd4, 32'h99, 32'h2, 32'd7};
        v_op    = '{4'b1100, 4'b0110, 4'b0010, 4'b0010, 4'b0111, 4'b1000, 4'b0011, 4'b0000, 4'b0000};
        v_a     = '{32'h0, 32'd10, 32'h100, 32'h2000, 32'd1, 32'd4, 32'h30, 32'h1, 32'h0};
        v_b     = '{32'hFFFFFFFF, 32'd3, 32'd8, 32'hFFFFFFFC, 32'd2, 32'd4, 32'd5, 32'hFF, 32'h0};
        v_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            instr = v_instr[i]; rs1_data = v_rs1[i]; rs2_data = v_rs2[i]; in_valid = 1'b1;
            step();
            if (v_ill[i]) exp_cnt++;
            n_checks++; if (out_valid !== 1'b1) $display("FAIL dec%0d_valid got=%b exp=1", i, out_valid); else n_pass++;
            n_checks++; if (Operation !== v_op[i]) $display("FAIL dec%0d_op got=%b exp=%b", i, Operation, v_op[i]); else n_pass++;
            n_checks++; if (SrcA !== v_a[i]) $display("FAIL dec%0d_srca got=%h exp=%h", i, SrcA, v_a[i]); else n_pass++;
            n_checks++; if (SrcB !== v_b[i]) $display("FAIL dec%0d_srcb got=%h exp=%h", i, SrcB, v_b[i]); else n_pass++;
            n_checks++; if (out_illegal !== v_ill[i]) $display("FAIL dec%0d_illegal got=%b exp=%b", i, out_illegal, v_ill[i]); else n_pass++;
            $display("decode %0d: instr=%h op=%b a=%h b=%h ill=%b", i, v_instr[i], Operation, SrcA, SrcB, out_illegal);
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (illegal_cnt !== 8'(exp_cnt)) $display("FAIL dec_cnt got=%0d exp=%0d", illegal_cnt, exp_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        instr = 32'h0020A423; rs1_data = 32'h100; rs2_data = 32'h77;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready0 got=%b exp=0", in_ready); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if (out_valid !== 1'b1) $display("FAIL bp%0d_valid got=%b exp=1", c, out_valid); else n_pass++;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp%0d_in_ready got=%b exp=0", c, in_ready); else n_pass++;
            n_checks++; if ({Operation, SrcA, SrcB} !== {4'b0010, 32'h100, 32'd8})
                $display("FAIL bp%0d_payload got=%b/%h/%h exp=0010/00000100/00000008", c, Operation, SrcA, SrcB);
            else n_pass++;
            $display("stall %0d: op=%b a=%h b=%h", c, Operation, SrcA, SrcB);
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready1 got=%b exp=1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_refill_valid got=%b exp=1", out_valid); else n_pass++;
        n_checks++; if ({Operation, SrcA, SrcB} !== {4'b0010, 32'd5, 32'd7})
            $display("FAIL bp_refill_payload got=%b/%h/%h exp=0010/00000005/00000007", Operation, SrcA, SrcB);
        else n_pass++;
        $display("refill: op=%b a=%h b=%h", Operation, SrcA, SrcB);
        step();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_flush();
        instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b1; instr = 32'hFFFFFFFF;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_offer_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if (illegal_cnt !== 8'(exp_cnt)) $display("FAIL flush_cnt got=%0d exp=%0d", illegal_cnt, exp_cnt); else n_pass++;
        $display("flush with offer: out_valid=%b cnt=%0d", out_valid, illegal_cnt);
        instr = 32'h002081B3; in_valid = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_stall_valid got=%b exp=0", out_valid); else n_pass++;
        $display("flush mid-stall: out_valid=%b", out_valid);
        out_ready = 1'b1;
    endtask

    task automatic test_illegal();
        instr = 32'hFFFFFFFF; rs1_data = 32'h1234; rs2_data = 32'h5678;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        exp_cnt++;
        n_checks++; if (out_illegal !== 1'b1) $display("FAIL ill_flag got=%b exp=1", out_illegal); else n_pass++;
        n_checks++; if (Operation !== 4'b0000) $display("FAIL ill_op got=%b exp=0000", Operation); else n_pass++;
        n_checks++; if ({SrcA, SrcB} !== 64'h0) $display("FAIL ill_src got=%h/%h exp=0/0", SrcA, SrcB); else n_pass++;
        n_checks++; if (illegal_cnt !== 8'(exp_cnt)) $display("FAIL ill_cnt got=%0d exp=%0d", illegal_cnt, exp_cnt); else n_pass++;
        $display("illegal: flag=%b op=%b cnt=%0d", out_illegal, Operation, illegal_cnt);
        step();
    endtask

    task automatic test_saturation();
        instr = 32'hFFFFFFFF; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 300; k++) step();
        in_valid = 1'b0;
        n_checks++; if (illegal_cnt !== 8'd255) $display("FAIL sat_cnt got=%0d exp=255", illegal_cnt); else n_pass++;
        $display("saturation: cnt=%0d", illegal_cnt);
        step();
    endtask

    task automatic test_reset_mid_stall();
        instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL rst_stall_pre got=%b exp=1", out_valid); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_stall_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if ({SrcA, SrcB, Operation} !== 68'h0) $display("FAIL rst_stall_payload got=%h/%h/%b exp=0", SrcA, SrcB, Operation); else n_pass++;
        n_checks++; if (illegal_cnt !== 8'd0) $display("FAIL rst_stall_cnt got=%0d exp=0", illegal_cnt); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_stall_in_ready got=%b exp=1", in_ready); else n_pass++;
        $display("reset mid-stall: out_valid=%b cnt=%0d", out_valid, illegal_cnt);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_decode_table();
        test_backpressure();
        test_flush();
        test_illegal();
        test_saturation();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
